cyc_enc_arbiter: RTL

//   Shares one bit-serial (7,4) systematic cyclic encoder, g(x)=x^3+x+1, between NREQ requesters.
//   A round-robin arbiter grants one requester at a time. The encoder shifts the 4 message bits

---
 rtl/cyc_enc_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cyc_enc_arbiter.sv
// Round-robin arbiter in front of one shared bit-serial (7,4) cyclic encoder, g(x)=x^3+x+1.
// A granted message is shifted MSB-first through a 3-bit LFSR and returned as {parity, message}.
module cyc_enc_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [6:0]        out_code,
  output logic [ID_W-1:0]   out_id,
  input  logic              out_ready,
  output logic              busy
);

  // state | meaning
  // IDLE  | arbitrate; grant and latch the winning message
  // SHIFT | four cycles, one message bit per cycle into the LFSR
  // DONE  | codeword presented, held until out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]      lfsr_q, lfsr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      u_q, u_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            found;
  logic [NREQ-1:0] gnt_onehot;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] gnt_nxt;
  logic [3:0]      gnt_data;
  logic            fb;

  // Distance of requester k from the pointer, walking upward with wrap.
  function automatic int ring_dist(input int k, input logic [ID_W-1:0] p);
    int d;
    d = k - int'(p);
    if (d < 0) d = d + NREQ;
    return d;
  endfunction

  always_comb begin
    found      = 1'b0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_nxt    = '0;
    gnt_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid[k] && ring_dist(k, rr_ptr_q) == i) begin
          found         = 1'b1;
          gnt_onehot[k] = 1'b1;
          gnt_idx       = ID_W'(k);
          gnt_nxt       = ID_W'((k + 1) % NREQ);
          gnt_data      = req_data[4*k +: 4];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    u_d       = u_q;
    id_d      = id_q;
    fb        = 1'b0;
    req_ready = '0;
    out_valid = 1'b0;
    out_code  = '0;
    out_id    = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = gnt_onehot;
        if (found) begin
          u_d      = gnt_data;
          id_d     = gnt_idx;
          lfsr_d   = 3'b000;
          cnt_d    = 2'd0;
          rr_ptr_d = gnt_nxt;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        fb     = u_q[2'd3 - cnt_q] ^ lfsr_q[2];
        lfsr_d = {lfsr_q[1], lfsr_q[0] ^ fb, fb};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_code  = {lfsr_q, u_q};
        out_id    = id_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      u_q      <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      u_q      <= u_d;
      id_q     <= id_d;
    end
  end

endmodule
